// File: rtl/multisim_pull_downsizer.sv
// Width downsizer between the multisim pull client and the DUT.
// Wide words are queued in a 2-entry FIFO and replayed as RATIO narrow beats,
// least-significant slice first, with out_last flagging the final slice.
// in_rdy depends only on flops and rst, so the client can sample it race-free.
module multisim_pull_downsizer #(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_rdy,
  output logic                 out_vld,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_rdy,
  output logic [31:0]          word_count
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned BeatW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(RATIO - 1);

  if (OUT_WIDTH > IN_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_params
    $error("multisim_pull_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] mem_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [31:0]         word_count_q, word_count_d;
  logic [IN_WIDTH-1:0] head;
  logic                push, beat_fire, pop;

  // rst gates in_rdy directly so the client holds its word during reset.
  assign in_rdy     = ~rst & (count_q != 2'd2);
  assign out_vld    = (count_q != 2'd0);
  assign out_last   = (beat_q == LastBeat);
  assign head       = mem_q[rd_ptr_q];
  assign push       = in_vld & in_rdy;
  assign beat_fire  = out_vld & out_rdy;
  assign pop        = beat_fire & out_last;
  assign word_count = word_count_q;

  // Select the current slice of the head word.
  always_comb begin
    out_data = head[OUT_WIDTH-1:0];
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (beat_q == BeatW'(i)) begin
        out_data = head[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Next-state for pointers, occupancy, beat counter and word counter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_d       = beat_q;
    word_count_d = word_count_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (beat_fire) begin
      if (out_last) begin
        beat_d       = '0;
        rd_ptr_d     = ~rd_ptr_q;
        word_count_d = word_count_q + 32'd1;
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any partial or queued word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      beat_q       <= '0;
      word_count_q <= 32'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      word_count_q <= word_count_d;
    end
  end

  // Data storage needs no reset; contents are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_multisim_pull_downsizer.sv
// Directed bench for multisim_pull_downsizer (64->16 and 32->32 instances).
module tb_multisim_pull_downsizer;

  localparam int unsigned R  = 4;
  localparam int unsigned OW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_vld = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_rdy;
  logic        out_vld;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_rdy = 1'b0;
  logic [31:0] word_count;

  logic        in_vld1 = 1'b0;
  logic [31:0] in_data1 = '0;
  logic        in_rdy1;
  logic        out_vld1;
  logic [31:0] out_data1;
  logic        out_last1;
  logic        out_rdy1 = 1'b0;
  logic [31:0] word_count1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multisim_pull_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
    .word_count(word_count)
  );

  multisim_pull_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld1), .in_data(in_data1), .in_rdy(in_rdy1),
    .out_vld(out_vld1), .out_data(out_data1), .out_last(out_last1), .out_rdy(out_rdy1),
    .word_count(word_count1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench model: words still to send, beats pushed but not yet emitted.
  logic [63:0] src[$];
  logic [15:0] exp_data[$];
  logic        exp_last[$];
  logic [15:0] got_log[$];
  int          cyc_log[$];
  int          exp_wc = 0;
  int          beats_out = 0;
  int          rdy_mode = 0;
  int          in_low_run = 0;
  int          in_low_max = 0;
  int          push_cyc = -1;

  function automatic int model_words();
    return (exp_data.size() + R - 1) / R;
  endfunction

  task automatic drive();
    in_vld  = (src.size() != 0);
    in_data = in_vld ? src[0] : 64'd0;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  endtask

  task automatic step();
    logic        in_fire, out_fire;
    logic [63:0] w;
    @(negedge clk);
    check("out_vld", out_vld, exp_data.size() != 0);
    check("in_rdy", in_rdy, !rst && model_words() != 2);
    check("word_count", word_count, exp_wc);
    if (exp_data.size() != 0) begin
      check("out_data", out_data, exp_data[0]);
      check("out_last", out_last, exp_last[0]);
    end
    if (!in_rdy && !rst) in_low_run++;
    else in_low_run = 0;
    if (in_low_run > in_low_max) in_low_max = in_low_run;
    in_fire  = in_vld && in_rdy;
    out_fire = out_vld && out_rdy;
    if (out_fire && exp_data.size() != 0) begin
      if (exp_last[0]) exp_wc++;
      got_log.push_back(out_data);
      cyc_log.push_back(cyc);
      void'(exp_data.pop_front());
      void'(exp_last.pop_front());
      beats_out++;
    end
    if (in_fire && src.size() != 0) begin
      w = src.pop_front();
      push_cyc = cyc;
      for (int i = 0; i < R; i++) begin
        exp_data.push_back(w[i*OW +: OW]);
        exp_last.push_back(i == R - 1);
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_until_empty(input string tag, input int max_cycles);
    int n = 0;
    while ((src.size() != 0 || exp_data.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_drained"}, src.size() + exp_data.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src.delete(); exp_data.delete(); exp_last.delete();
    got_log.delete(); cyc_log.delete();
    exp_wc = 0; beats_out = 0; in_low_run = 0; in_low_max = 0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] bp_exp [12] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                               16'hB000, 16'hB001, 16'hB002, 16'hB003,
                               16'hC000, 16'hC001, 16'hC002, 16'hC003};

  initial begin
    int n, n_in, n_out;
    logic in_fire, out_fire;

    // Reset state, checked while rst is still asserted.
    #1 rst = 1'b1;
    #2;
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_word_count", word_count, 0);
    check("rst_out_vld1", out_vld1, 0);
    check("rst_out_last1", out_last1, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word.
    rdy_mode = 0;
    src.push_back(64'h4444_3333_2222_1111);
    drive();
    run_until_empty("single", 20);
    check("single_nbeats", got_log.size(), 4);
    if (got_log.size() == 4) begin
      check("single_b0", got_log[0], 16'h1111);
      check("single_b1", got_log[1], 16'h2222);
      check("single_b2", got_log[2], 16'h3333);
      check("single_b3", got_log[3], 16'h4444);
      check("single_contig", cyc_log[3] - cyc_log[0], 3);
      check("single_latency", cyc_log[0] - push_cyc, 1);
    end
    check("single_wc", word_count, 1);

    // Streaming 10 words, out_rdy held high.
    do_reset();
    rdy_mode = 0;
    for (int k = 0; k < 10; k++) begin
      src.push_back({12'(k), 4'd3, 12'(k), 4'd2, 12'(k), 4'd1, 12'(k), 4'd0});
    end
    drive();
    run_until_empty("stream", 100);
    check("stream_nbeats", got_log.size(), 40);
    if (got_log.size() == 40) begin
      check("stream_contig", cyc_log[39] - cyc_log[0], 39);
      check("stream_b0", got_log[0], 16'h0000);
      check("stream_b39", got_log[39], 16'h0093);
    end
    check("stream_in_low_le3", in_low_max <= 3, 1);
    check("stream_wc", word_count, 10);

    // Backpressure: downstream stalls for 20 cycles.
    do_reset();
    rdy_mode = 2;
    src.push_back(64'hA003_A002_A001_A000);
    src.push_back(64'hB003_B002_B001_B000);
    src.push_back(64'hC003_C002_C001_C000);
    drive();
    for (int i = 0; i < 20; i++) step();
    check("bp_out_vld", out_vld, 1);
    check("bp_out_data", out_data, 16'hA000);
    check("bp_in_rdy", in_rdy, 0);
    check("bp_third_held", src.size(), 1);
    rdy_mode = 0;
    drive();
    run_until_empty("bp", 40);
    check("bp_nbeats", got_log.size(), 12);
    if (got_log.size() == 12) begin
      for (int i = 0; i < 12; i++) check($sformatf("bp_b%0d", i), got_log[i], bp_exp[i]);
    end
    check("bp_wc", word_count, 3);

    // Random out_rdy, 1000 words.
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) src.push_back({$urandom(), $urandom()});
    drive();
    run_until_empty("rand", 20000);
    check("rand_nbeats", got_log.size(), 4000);
    check("rand_wc", word_count, 1000);

    // Reset mid-word with a word queued behind it.
    do_reset();
    rdy_mode = 0;
    src.push_back(64'hAAA3_AAA2_AAA1_AAA0);
    src.push_back(64'hBBB3_BBB2_BBB1_BBB0);
    src.push_back(64'hCCC3_CCC2_CCC1_CCC0);
    src.push_back(64'hDDD3_DDD2_DDD1_DDD0);
    drive();
    n = 0;
    while (beats_out < 2 && n < 20) begin
      step();
      n++;
    end
    check("mid_two_beats", beats_out, 2);
    #3 rst = 1'b1;
    #1;
    check("mid_out_vld", out_vld, 0);
    check("mid_in_rdy", in_rdy, 0);
    check("mid_wc", word_count, 0);
    exp_data.delete(); exp_last.delete(); exp_wc = 0;
    step();
    step();
    rst = 1'b0;
    got_log.delete();
    run_until_empty("mid", 40);
    check("mid_nbeats", got_log.size(), 8);
    if (got_log.size() == 8) begin
      check("mid_first_beat", got_log[0], 16'hCCC0);
      check("mid_d_beat", got_log[4], 16'hDDD0);
    end
    check("mid_wc_after", word_count, 2);

    // RATIO == 1 instance: stall first, then drain.
    do_reset();
    n_in = 0; n_out = 0;
    out_rdy1 = 1'b0;
    in_vld1  = 1'b1;
    in_data1 = 32'hA5A5_0001;
    for (int i = 0; i < 60 && n_out < 5; i++) begin
      @(negedge clk);
      if (i == 6) begin
        check("r1_stall_in_rdy", in_rdy1, 0);
        check("r1_stall_out_vld", out_vld1, 1);
        check("r1_stall_data", out_data1, 32'hA5A5_0001);
        check("r1_stall_accepted", n_in, 2);
      end
      in_fire  = in_vld1 && in_rdy1;
      out_fire = out_vld1 && out_rdy1;
      if (out_fire) begin
        check($sformatf("r1_data%0d", n_out), out_data1, 32'hA5A5_0001 + n_out);
        check($sformatf("r1_last%0d", n_out), out_last1, 1);
        n_out++;
      end
      if (in_fire) n_in++;
      @(posedge clk);
      #1;
      in_vld1  = (n_in < 5);
      in_data1 = 32'hA5A5_0001 + n_in;
      out_rdy1 = (i >= 6);
    end
    check("r1_nout", n_out, 5);
    @(negedge clk);
    check("r1_wc", word_count1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
